qspi_flash_reader: RTL
======================

QSPI_FLASH_READER -- requirements
Module: qspi_flash_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, flash byte address width; multiple of 8 (24 or 32).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, response word width; multiple of 8 (8/16/32).
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 SHALL have parameter QUAD, default 1: 1 = command 0x6B (1-1-4 quad output read); 0 = command 0x03 (1-1-1 read).
REQ-005 SHALL have parameter DUMMY_CYCLES, default 8, SCK cycles between address and data; used only when QUAD=1.
REQ-006 SHALL have parameter CLK_DIV, default 1 (min 1), SCK half-period in clk cycles.
REQ-007 SHALL have parameter CS_HIGH_CYCLES, default 4 (min 1), minimum qspi_cs high time between transactions, in clk cycles.
REQ-008 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 req_valid  input  1  read request present.
REQ-011 req_ready  output  1  block accepts request this cycle.
REQ-012 req_addr  input  ADDR_WIDTH  start byte address.
REQ-013 req_len  input  LEN_WIDTH  burst length in words minus one.
REQ-014 rsp_valid  output  1  rsp_data holds a word.
REQ-015 rsp_ready  input  1  consumer accepts word.
REQ-016 rsp_data  output  DATA_WIDTH  received word; first-received bit is MSB.
REQ-017 rsp_last  output  1  marks the final word of a burst.
REQ-018 qspi_clk  output  1  flash SCK, SPI mode 0 (idle low).
REQ-019 qspi_cs  output  1  flash chip select, active low.
REQ-020 qspi_dq_o  output  4  flash data out, lanes io0..io3.
REQ-021 qspi_dq_oe  output  4  per-lane output enable; pad tristating is done outside the block.
REQ-022 qspi_dq_i  input  4  flash data in.

Function
REQ-023 A handshake SHALL occur when req_valid && req_ready; req_ready SHALL be 1 only in IDLE with the CS-high timer expired; addr and len SHALL be latched at the handshake.
REQ-024 The state machine SHALL have states IDLE -> CMD -> ADDR -> DUMMY (QUAD=1 and DUMMY_CYCLES>0 only) -> DATA -> CSHIGH -> IDLE.
REQ-025 qspi_cs SHALL go low on the clk edge after the handshake; the first SCK rising edge SHALL occur no earlier than CLK_DIV clk cycles later.
REQ-026 SCK timing: each SCK half-period SHALL be exactly CLK_DIV clk cycles; outputs SHALL change only while SCK is low; qspi_dq_i SHALL be sampled on the clk edge that ends an SCK-high half-period.
REQ-027 CMD SHALL shift 8 command bits MSB first on io0 with qspi_dq_oe=4'b0001; io2 and io3 SHALL be held 1 via oe (write-protect/hold inactive) only when QUAD=0; when QUAD=1, oe=4'b0001 in CMD/ADDR.
REQ-028 ADDR SHALL shift ADDR_WIDTH bits MSB first on io0, one bit per SCK.
REQ-029 DUMMY SHALL issue DUMMY_CYCLES SCKs with qspi_dq_oe=0.
REQ-030 In DATA, qspi_dq_oe SHALL be 0; QUAD=1 SHALL capture 4 bits per SCK as {io3,io2,io1,io0}; QUAD=0 SHALL capture io1 as 1 bit per SCK.
REQ-031 Each word SHALL take DATA_WIDTH/4 SCKs (QUAD=1) or DATA_WIDTH SCKs (QUAD=0); the flash address increments implicitly (continuous read).
REQ-032 On word completion, rsp_valid SHALL rise on the next clk with rsp_data; rsp_last=1 on word number req_len+1.
REQ-033 Backpressure: if the previous word is still unaccepted (rsp_valid && !rsp_ready) when the next word would complete, SCK SHALL be held low (stalled) until accepted; no word is lost or duplicated.
REQ-034 rsp_valid/rsp_data/rsp_last SHALL stay stable until accepted; rsp_valid SHALL drop the cycle after acceptance unless a new word is presented.
REQ-035 After the last word completes, SCK SHALL return low, qspi_cs SHALL go high, and the block SHALL stay in CSHIGH for CS_HIGH_CYCLES before IDLE; the final rsp may still be pending while in IDLE.
REQ-036 A new request SHALL NOT be accepted while the final rsp is unaccepted.
REQ-037 Address counters SHALL wrap modulo 2^ADDR_WIDTH; no error is flagged.
REQ-038 req_len=2^LEN_WIDTH-1 SHALL deliver 2^LEN_WIDTH words.

Reset
REQ-039 While rst=0 the block SHALL have: state IDLE; qspi_cs=1; qspi_clk=0; qspi_dq_oe=0; qspi_dq_o=0; rsp_valid=0; rsp_last=0; rsp_data=0; req_ready=0.
REQ-040 On rst deassertion, req_ready SHALL be 1 on the first clk edge after the CS-high timer expires.
REQ-041 Reset asserted mid-transaction SHALL immediately force the REQ-039 values; partial data SHALL be discarded.

Verification
REQ-042 QUAD=1, CLK_DIV=1, addr 0x000000, len 0, flash holds 0x12 0x34 -> cmd 0x6B, 24 addr bits, 8 dummy, one rsp 0x1234 with rsp_last=1; total 8+24+8+4=44 SCKs.
REQ-043 QUAD=0, addr 0x000100, len 3, DATA_WIDTH=16 -> cmd 0x03, no dummy, 4 words matching flash bytes 0x100..0x107 in order, rsp_last on the 4th only.
REQ-044 rsp_ready held 0 for 20 cycles after the first word of a len=2 burst -> SCK stalled low, words 2..3 correct, no loss or duplication.
REQ-045 rst pulsed low in mid-ADDR phase -> same-cycle cs=1, sck=0, oe=0; a following request runs a clean full transaction.
REQ-046 Back-to-back requests with CS_HIGH_CYCLES=4 -> cs high for at least 4 clk cycles between transactions; req_ready=0 throughout.
REQ-047 CLK_DIV=3, addr 0xFFFFFE, len 1 -> SCK period 6 clk cycles; data from 0xFFFFFE..0x000001 is returned per flash wrap.

Source files
------------

// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: burst reader for SPI NOR flash using continuous 0x03 (1-1-1) or 0x6B (1-1-4) reads
module qspi_flash_reader #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 8,
  parameter int QUAD           = 1,
  parameter int DUMMY_CYCLES   = 8,
  parameter int CLK_DIV        = 1,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  qspi_clk,
  output logic                  qspi_cs,
  output logic [3:0]            qspi_dq_o,
  output logic [3:0]            qspi_dq_oe,
  input  logic [3:0]            qspi_dq_i
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_CSHIGH = 3'd5;
  localparam int SW  = (QUAD != 0) ? DATA_WIDTH / 4 : DATA_WIDTH;
  localparam int OW  = ADDR_WIDTH + 8;
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW  = $clog2(CS_HIGH_CYCLES + 1);
  localparam logic [7:0] CMD = (QUAD != 0) ? 8'h6B : 8'h03;
  localparam logic [2:0] S_POST_ADDR = (QUAD != 0 && DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;

  logic [2:0]            state_q, state_d;
  logic [DVW-1:0]        div_q, div_d;
  logic                  sck_q, sck_d;
  logic [7:0]            bit_q, bit_d;
  logic [OW-1:0]         osr_q, osr_d;
  logic [DATA_WIDTH-1:0] isr_q, isr_d;
  logic [LEN_WIDTH-1:0]  word_q, word_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  busy, tick, bit_last, stall, rise, fall, done_word, done_last, accept, shifting;
  logic [7:0]            lim;
  logic [DATA_WIDTH-1:0] shift_in;

  assign busy      = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign shifting  = state_q == S_CMD || state_q == S_ADDR;
  assign tick      = div_q == DVW'(CLK_DIV - 1);
  assign lim       = (state_q == S_CMD)   ? 8'd7 :
                     (state_q == S_ADDR)  ? 8'(ADDR_WIDTH - 1) :
                     (state_q == S_DUMMY) ? 8'(DUMMY_CYCLES - 1) : 8'(SW - 1);
  assign bit_last  = bit_q == lim;
  // Only the SCK that would complete a word waits for the consumer; earlier bits keep streaming.
  assign stall     = state_q == S_DATA && bit_last && rsp_valid_q && !rsp_ready;
  assign rise      = busy && !sck_q && tick && !stall;
  assign fall      = busy && sck_q && tick;
  assign done_word = fall && state_q == S_DATA && bit_last;
  assign done_last = done_word && word_q == len_q;
  assign accept    = req_valid && req_ready;
  assign shift_in  = (QUAD != 0) ? {isr_q[DATA_WIDTH-5:0], qspi_dq_i} : {isr_q[DATA_WIDTH-2:0], qspi_dq_i[1]};

  assign req_ready  = state_q == S_IDLE && tmr_q == '0 && !rsp_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign qspi_clk   = sck_q;
  assign qspi_cs    = !busy;
  // In single-lane mode io2/io3 are driven high to keep WP#/HOLD# inactive.
  assign qspi_dq_oe = shifting ? ((QUAD != 0) ? 4'b0001 : 4'b1101) : 4'b0000;
  assign qspi_dq_o  = shifting ? {(QUAD != 0) ? 2'b00 : 2'b11, 1'b0, osr_q[OW-1]} : 4'b0000;

  always_comb begin
    div_d       = !busy ? '0 : tick ? (stall ? div_q : '0) : div_q + 1'b1;
    sck_d       = (rise || fall) ? ~sck_q : sck_q;
    bit_d       = fall ? (bit_last ? 8'd0 : bit_q + 8'd1) : bit_q;
    osr_d       = accept ? {CMD, req_addr} : fall ? {osr_q[OW-2:0], 1'b0} : osr_q;
    isr_d       = (fall && state_q == S_DATA) ? shift_in : isr_q;
    len_d       = accept ? req_len : len_q;
    word_d      = accept ? '0 : done_word ? word_q + 1'b1 : word_q;
    tmr_d       = done_last ? TW'(CS_HIGH_CYCLES - 1) :
                  ((state_q == S_IDLE || state_q == S_CSHIGH) && tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    rsp_valid_d = done_word || (rsp_valid_q && !rsp_ready);
    rsp_data_d  = done_word ? shift_in : rsp_data_q;
    rsp_last_d  = done_word ? word_q == len_q : rsp_last_q;
    state_d     = state_q;
    case (state_q)
      S_IDLE:   state_d = accept ? S_CMD : S_IDLE;
      S_CMD:    state_d = (fall && bit_last) ? S_ADDR : S_CMD;
      S_ADDR:   state_d = (fall && bit_last) ? S_POST_ADDR : S_ADDR;
      S_DUMMY:  state_d = (fall && bit_last) ? S_DATA : S_DUMMY;
      S_DATA:   state_d = done_last ? S_CSHIGH : S_DATA;
      S_CSHIGH: state_d = (tmr_q == '0) ? S_IDLE : S_CSHIGH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      sck_q       <= 1'b0;
      bit_q       <= '0;
      osr_q       <= '0;
      isr_q       <= '0;
      word_q      <= '0;
      len_q       <= '0;
      tmr_q       <= TW'(CS_HIGH_CYCLES);
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sck_q       <= sck_d;
      bit_q       <= bit_d;
      osr_q       <= osr_d;
      isr_q       <= isr_d;
      word_q      <= word_d;
      len_q       <= len_d;
      tmr_q       <= tmr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
endmodule
